operand_fetch: RTL and testbench

//  Register-read stage between instruction decode and the ALU. Accepts one decoded op per

---
 rtl/operand_fetch.sv | 105 ++++++++++
 tb/tb_operand_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Register-read stage: captures an op with its two operands into a 2-entry skid buffer,
// forwarding writeback data both at capture time and into entries already held.
module operand_fetch #(
    parameter int RWIDTH  = 6,
    parameter int DWIDTH  = 32,
    parameter int OPWIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPWIDTH-1:0] in_op,
    input  logic [RWIDTH-1:0]  in_rs1,
    input  logic [RWIDTH-1:0]  in_rs2,
    input  logic [RWIDTH-1:0]  in_rd,
    input  logic [DWIDTH-1:0]  in_imm,
    output logic [RWIDTH-1:0]  ra1,
    output logic [RWIDTH-1:0]  ra2,
    input  logic [DWIDTH-1:0]  rd1,
    input  logic [DWIDTH-1:0]  rd2,
    input  logic               wb_we,
    input  logic [RWIDTH-1:0]  wb_wa,
    input  logic [DWIDTH-1:0]  wb_wd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPWIDTH-1:0] out_op,
    output logic [RWIDTH-1:0]  out_rd,
    output logic [DWIDTH-1:0]  out_a,
    output logic [DWIDTH-1:0]  out_b,
    output logic [DWIDTH-1:0]  out_imm
);

    typedef struct packed {
        logic               vld;
        logic [OPWIDTH-1:0] op;
        logic [RWIDTH-1:0]  rd;
        logic [RWIDTH-1:0]  rs1;
        logic [RWIDTH-1:0]  rs2;
        logic [DWIDTH-1:0]  a;
        logic [DWIDTH-1:0]  b;
        logic [DWIDTH-1:0]  imm;
    } entry_t;

    entry_t head, skid;
    entry_t incoming, head_byp, skid_byp;
    logic   accept, pop, wb_hit;

    assign ra1       = in_rs1;
    assign ra2       = in_rs2;
    // skid occupancy is the only thing that can stall decode, so in_ready is a pure register
    assign in_ready  = !skid.vld;
    assign out_valid = head.vld;
    assign accept    = in_valid && in_ready;
    assign pop       = head.vld && out_ready;
    assign wb_hit    = wb_we && (wb_wa != '0);

    assign out_op  = head.op;
    assign out_rd  = head.rd;
    assign out_a   = head.a;
    assign out_b   = head.b;
    assign out_imm = head.imm;

    always_comb begin
        incoming     = '0;
        incoming.vld = 1'b1;
        incoming.op  = in_op;
        incoming.rd  = in_rd;
        incoming.rs1 = in_rs1;
        incoming.rs2 = in_rs2;
        incoming.imm = in_imm;
        incoming.a   = (wb_hit && wb_wa == in_rs1) ? wb_wd : rd1;
        incoming.b   = (wb_hit && wb_wa == in_rs2) ? wb_wd : rd2;

        // held entries track writes to their sources so they never go stale while stalled
        head_byp = head;
        skid_byp = skid;
        if (wb_hit && head.rs1 == wb_wa) head_byp.a = wb_wd;
        if (wb_hit && head.rs2 == wb_wa) head_byp.b = wb_wd;
        if (wb_hit && skid.rs1 == wb_wa) skid_byp.a = wb_wd;
        if (wb_hit && skid.rs2 == wb_wa) skid_byp.b = wb_wd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            head <= head_byp;
            skid <= skid_byp;
            if (!head.vld || pop) begin
                if (skid.vld) begin
                    head     <= skid_byp;
                    skid.vld <= 1'b0;
                end else if (accept) begin
                    head <= incoming;
                end else begin
                    head.vld <= 1'b0;
                end
            end else if (accept) begin
                skid <= incoming;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: accepted ops are queued with their expected operands,
// writebacks are applied to queued entries, and the head is compared whenever out_valid is high.
module tb_operand_fetch;
    localparam int RW = 6;
    localparam int DW = 32;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_op;
    logic [RW-1:0] in_rs1, in_rs2, in_rd;
    logic [DW-1:0] in_imm;
    logic [RW-1:0] ra1, ra2;
    logic [DW-1:0] rd1, rd2;
    logic          wb_we;
    logic [RW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_op;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_a, out_b, out_imm;

    operand_fetch #(.RWIDTH(RW), .DWIDTH(DW), .OPWIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .out_imm(out_imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] op;
        logic [RW-1:0] rd, rs1, rs2;
        logic [DW-1:0] a, b, imm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Advance one clock, updating the scoreboard with what the edge is expected to do.
    task automatic tick();
        exp_t e, d;
        bit   acc, pp;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (pp && sb.size() > 0) d = sb.pop_front();
            if (wb_we && wb_wa != 0) begin
                foreach (sb[i]) begin
                    if (sb[i].rs1 == wb_wa) sb[i].a = wb_wd;
                    if (sb[i].rs2 == wb_wa) sb[i].b = wb_wd;
                end
            end
            if (acc) begin
                e.op  = in_op;  e.rd  = in_rd;  e.rs1 = in_rs1; e.rs2 = in_rs2; e.imm = in_imm;
                e.a   = (wb_we && wb_wa != 0 && wb_wa == in_rs1) ? wb_wd : rd1;
                e.b   = (wb_we && wb_wa != 0 && wb_wa == in_rs2) ? wb_wd : rd2;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OW-1:0] op, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [RW-1:0] rd, input logic [DW-1:0] imm,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
        rd1 = (rs1 == 0) ? '0 : d1;
        rd2 = (rs2 == 0) ? '0 : d2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; wb_we = 1'b0;
        in_op = 6'h3; in_rs1 = 6'd1; in_rs2 = 6'd2; in_rd = 6'd3; in_imm = 32'h5;
        rd1 = 32'h77; rd2 = 32'h88; wb_wa = '0; wb_wd = '0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if ({out_op, out_rd, out_a, out_b, out_imm} !== '0)
            begin n_err++; $display("FAIL reset_outputs: got a=%0h b=%0h op=%0h expected 0", out_a, out_b, out_op); end
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_release: got %0b expected 0", out_valid); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(6'h2a, 6'd3, 6'd4, 6'd9, 32'hdead_beef, 32'h11, 32'h22);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b expected 1", out_valid); end
        n_cmp++; if (out_a !== 32'h11 || out_b !== 32'h22)
            begin n_err++; $display("FAIL basic_operands: got %0h/%0h expected 11/22", out_a, out_b); end
        n_cmp++; if (out_op !== 6'h2a || out_rd !== 6'd9 || out_imm !== 32'hdead_beef)
            begin n_err++; $display("FAIL basic_passthru: got op=%0h rd=%0d imm=%0h expected 2a/9/deadbeef", out_op, out_rd, out_imm); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        drive(6'h1, 6'd5, 6'd6, 6'd1, 32'h0, 32'hAAAA, 32'hBBBB);
        wb_we = 1'b1; wb_wa = 6'd5; wb_wd = 32'h1234;
        tick();
        in_valid = 1'b0; wb_we = 1'b0;
        n_cmp++; if (out_a !== 32'h1234 || out_b !== 32'hBBBB)
            begin n_err++; $display("FAIL bypass_same_cycle: got %0h/%0h expected 1234/bbbb", out_a, out_b); end
        drive(6'h2, 6'd0, 6'd0, 6'd2, 32'h0, 32'hAAAA, 32'hAAAA);
        wb_we = 1'b1; wb_wa = 6'd0; wb_wd = 32'h5555;
        tick();
        in_valid = 1'b0; wb_we = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'h0 || out_b !== 32'h0)
            begin n_err++; $display("FAIL bypass_r0: got v=%0b %0h/%0h expected 1 0/0", out_valid, out_a, out_b); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(6'h11, 6'd1, 6'd2, 6'd3, 32'h100, 32'h1, 32'h2);
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %0b expected 1", in_ready); end
        drive(6'h12, 6'd2, 6'd3, 6'd4, 32'h200, 32'h3, 32'h4);
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %0b expected 0", in_ready); end
        drive(6'h13, 6'd4, 6'd5, 6'd6, 32'h300, 32'h5, 32'h6);
        tick(); tick();
        n_cmp++; if (sb.size() != 2 || in_ready !== 1'b0 || out_op !== 6'h11)
            begin n_err++; $display("FAIL bp_third_refused: got ready=%0b op=%0h expected 0/11", in_ready, out_op); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== (sb.size() != 0)) begin
                n_err++; $display("FAIL bp_drain_valid: got %0b expected %0b", out_valid, sb.size() != 0);
            end else if (sb.size() != 0 && {out_op, out_rd, out_a, out_b, out_imm} !== {sb[0].op, sb[0].rd, sb[0].a, sb[0].b, sb[0].imm}) begin
                n_err++; $display("FAIL bp_drain_order: got op=%0h a=%0h expected op=%0h a=%0h", out_op, out_a, sb[0].op, sb[0].a);
            end
            tick();
            if (i == 0) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop: got %0b expected 1", in_ready); end
            end
        end
    endtask

    task automatic test_stall_bypass();
        out_ready = 1'b0;
        drive(6'h21, 6'd1, 6'd7, 6'd8, 32'h0, 32'h1, 32'h5);
        tick();
        drive(6'h22, 6'd7, 6'd2, 6'd9, 32'h0, 32'h3, 32'h4);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_b !== 32'h5) begin n_err++; $display("FAIL stall_pre: got %0h expected 5", out_b); end
        wb_we = 1'b1; wb_wa = 6'd7; wb_wd = 32'h99;
        tick();
        wb_we = 1'b0;
        n_cmp++; if (out_b !== 32'h99 || out_a !== 32'h1)
            begin n_err++; $display("FAIL stall_head_bypass: got %0h/%0h expected 1/99", out_a, out_b); end
        // promotion edge carries another write to r7
        out_ready = 1'b1; wb_we = 1'b1; wb_wa = 6'd7; wb_wd = 32'h77;
        tick();
        wb_we = 1'b0; out_ready = 1'b0;
        n_cmp++; if (out_op !== 6'h22 || out_a !== 32'h77 || out_b !== 32'h4)
            begin n_err++; $display("FAIL stall_promote_bypass: got op=%0h a=%0h b=%0h expected 22/77/4", out_op, out_a, out_b); end
        n_cmp++; if (out_a !== sb[0].a) begin n_err++; $display("FAIL stall_sb: got %0h expected %0h", out_a, sb[0].a); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_throughput();
        int rst_at;
        out_ready = 1'b1;
        rst_at = $urandom_range(12, 18);
        for (int i = 0; i < 22; i++) begin
            if (i < 20) drive(6'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                              6'($urandom), $urandom, $urandom, $urandom);
            else in_valid = 1'b0;
            wb_we = 1'($urandom); wb_wa = 6'($urandom_range(0, 7)); wb_wd = $urandom;
            rst_n = (i != rst_at);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL tp_ready: cycle %0d got %0b expected 1", i, in_ready); end
            n_cmp++;
            if (out_valid !== (sb.size() != 0)) begin
                n_err++; $display("FAIL tp_valid: cycle %0d got %0b expected %0b", i, out_valid, sb.size() != 0);
            end else if (sb.size() != 0 && {out_op, out_rd, out_a, out_b, out_imm} !== {sb[0].op, sb[0].rd, sb[0].a, sb[0].b, sb[0].imm}) begin
                n_err++; $display("FAIL tp_head: cycle %0d got a=%0h b=%0h expected a=%0h b=%0h", i, out_a, out_b, sb[0].a, sb[0].b);
            end
            tick();
            if (i == rst_at) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL tp_reset: got %0b expected 0", out_valid); end
            end
        end
        rst_n = 1'b1; wb_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_stall_bypass();
        test_throughput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
